alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: req0 (execute stage) and req1 (address/branch-target unit).
- Arbitrates round-robin and registers the operands that drive the ALU.
- Waits a configurable settle time, then captures the result and comparison flags.
- Returns the response to the winning requester over a valid/ready handshake.

---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle between the ALU arbiter, its two requesters and the shared ALU.
// slave = arbiter side, master = requester/ALU side.
interface alu_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid_w_i_h, req0_ready_w_o_h;
  logic [3:0]      req0_op_w_i;
  logic [XLEN-1:0] req0_a_w_i, req0_b_w_i;
  logic            req1_valid_w_i_h, req1_ready_w_o_h;
  logic [3:0]      req1_op_w_i;
  logic [XLEN-1:0] req1_a_w_i, req1_b_w_i;
  logic            rsp0_valid_w_o_h, rsp0_ready_w_i_h;
  logic            rsp1_valid_w_o_h, rsp1_ready_w_i_h;
  logic [XLEN-1:0] rsp_res_w_o;
  logic [4:0]      rsp_flags_w_o;
  logic            rsp_err_w_o_h;
  logic [XLEN-1:0] alu_a_w_o, alu_b_w_o;
  logic [3:0]      alu_control_w_o;
  logic [XLEN-1:0] alu_res_w_i;
  logic            alu_eq_w_i_h, alu_ltu_w_i_h, alu_gteu_w_i_h, alu_lts_w_i_h, alu_gtes_w_i_h;
  logic            busy_w_o_h;

  modport slave (
    input  req0_valid_w_i_h, req0_op_w_i, req0_a_w_i, req0_b_w_i,
    input  req1_valid_w_i_h, req1_op_w_i, req1_a_w_i, req1_b_w_i,
    input  rsp0_ready_w_i_h, rsp1_ready_w_i_h,
    input  alu_res_w_i, alu_eq_w_i_h, alu_ltu_w_i_h, alu_gteu_w_i_h, alu_lts_w_i_h, alu_gtes_w_i_h,
    output req0_ready_w_o_h, req1_ready_w_o_h,
    output rsp0_valid_w_o_h, rsp1_valid_w_o_h, rsp_res_w_o, rsp_flags_w_o, rsp_err_w_o_h,
    output alu_a_w_o, alu_b_w_o, alu_control_w_o, busy_w_o_h
  );

  modport master (
    output req0_valid_w_i_h, req0_op_w_i, req0_a_w_i, req0_b_w_i,
    output req1_valid_w_i_h, req1_op_w_i, req1_a_w_i, req1_b_w_i,
    output rsp0_ready_w_i_h, rsp1_ready_w_i_h,
    output alu_res_w_i, alu_eq_w_i_h, alu_ltu_w_i_h, alu_gteu_w_i_h, alu_lts_w_i_h, alu_gtes_w_i_h,
    input  req0_ready_w_o_h, req1_ready_w_o_h,
    input  rsp0_valid_w_o_h, rsp1_valid_w_o_h, rsp_res_w_o, rsp_flags_w_o, rsp_err_w_o_h,
    input  alu_a_w_o, alu_b_w_o, alu_control_w_o, busy_w_o_h
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional ALU_ARB_OP_CHECK_EN: illegal ops bypass the ALU and return rsp_err.
module alu_arbiter #(
  parameter int ALU_LATENCY = 1,  // 1..15
  parameter int XLEN        = 32
) (
  input logic          clk_w_i,
  input logic          rst_w_i_l,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } req_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY - 1);

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            grant_q, grant_d;
  logic [3:0]      cnt_q, cnt_d;
  req_t            opr_q, opr_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      flags_q, flags_d;

  logic [1:0] req_vld, rsp_rdy, rdy;
  req_t [1:0] req;
  req_t       req_sel;
  logic       win, any_vld, acc, op_ill;

  assign req_vld = {bus.req1_valid_w_i_h, bus.req0_valid_w_i_h};
  assign rsp_rdy = {bus.rsp1_ready_w_i_h, bus.rsp0_ready_w_i_h};
  assign req[0]  = {bus.req0_op_w_i, bus.req0_a_w_i, bus.req0_b_w_i};
  assign req[1]  = {bus.req1_op_w_i, bus.req1_a_w_i, bus.req1_b_w_i};

  // Pointer only matters on contention; a lone requester always wins.
  assign win     = (&req_vld) ? ptr_q : req_vld[1];
  assign any_vld = |req_vld;
  assign acc     = (state_q == IDLE) && any_vld;
  assign req_sel = req[win];
  assign rdy     = {acc && win, acc && !win};

`ifdef ALU_ARB_OP_CHECK_EN
  logic err_q, err_d;
  assign op_ill = !((req_sel.op <= 4'd8) || (req_sel.op == 4'd13));
  assign bus.rsp_err_w_o_h = err_q;

  always_comb begin
    err_d = err_q;
    if (acc) err_d = op_ill;
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) err_q <= 1'b0;
    else            err_q <= err_d;
  end
`else
  assign op_ill            = 1'b0;
  assign bus.rsp_err_w_o_h = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    opr_d   = opr_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          grant_d = win;
          if (op_ill) begin
            // Operands untouched so the ALU inputs stay quiet.
            res_d   = '0;
            flags_d = '0;
            state_d = RESP;
          end else begin
            opr_d   = req_sel;
            cnt_d   = CNT_INIT;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d   = bus.alu_res_w_i;
          flags_d = {bus.alu_eq_w_i_h, bus.alu_ltu_w_i_h, bus.alu_gteu_w_i_h,
                     bus.alu_lts_w_i_h, bus.alu_gtes_w_i_h};
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_rdy[grant_q]) begin
          ptr_d   = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= '0;
      opr_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      opr_q   <= opr_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign bus.req0_ready_w_o_h = rdy[0];
  assign bus.req1_ready_w_o_h = rdy[1];
  assign bus.rsp0_valid_w_o_h = (state_q == RESP) && !grant_q;
  assign bus.rsp1_valid_w_o_h = (state_q == RESP) && grant_q;
  assign bus.rsp_res_w_o      = res_q;
  assign bus.rsp_flags_w_o    = flags_q;
  assign bus.alu_a_w_o        = opr_q.a;
  assign bus.alu_b_w_o        = opr_q.b;
  assign bus.alu_control_w_o  = opr_q.op;
  assign bus.busy_w_o_h       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LATENCY=1, one at 4,
// each driving a small behavioural ALU.
module tb_alu_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last = 0;
  logic got;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.XLEN(XLEN)) ifa ();
  alu_arbiter_if #(.XLEN(XLEN)) ifb ();

  alu_arbiter #(.ALU_LATENCY(1), .XLEN(XLEN)) dut1 (.clk_w_i(clk), .rst_w_i_l(rst_n), .bus(ifa));
  alu_arbiter #(.ALU_LATENCY(4), .XLEN(XLEN)) dut4 (.clk_w_i(clk), .rst_w_i_l(rst_n), .bus(ifb));

  // Stand-in ALU: 0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,13 and.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return {31'b0, $signed(a) < $signed(b)};
      4'd4:    return {31'b0, a < b};
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return 32'($signed(a) >>> b[4:0]);
      4'd8:    return a | b;
      4'd13:   return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] flg_f(input logic [31:0] a, input logic [31:0] b);
    return {a == b, a < b, a >= b, $signed(a) < $signed(b), $signed(a) >= $signed(b)};
  endfunction

  assign ifa.alu_res_w_i = alu_f(ifa.alu_control_w_o, ifa.alu_a_w_o, ifa.alu_b_w_o);
  assign {ifa.alu_eq_w_i_h, ifa.alu_ltu_w_i_h, ifa.alu_gteu_w_i_h, ifa.alu_lts_w_i_h,
          ifa.alu_gtes_w_i_h} = flg_f(ifa.alu_a_w_o, ifa.alu_b_w_o);
  assign ifb.alu_res_w_i = alu_f(ifb.alu_control_w_o, ifb.alu_a_w_o, ifb.alu_b_w_o);
  assign {ifb.alu_eq_w_i_h, ifb.alu_ltu_w_i_h, ifb.alu_gteu_w_i_h, ifb.alu_lts_w_i_h,
          ifb.alu_gtes_w_i_h} = flg_f(ifb.alu_a_w_o, ifb.alu_b_w_o);

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  initial begin
    {ifa.req0_valid_w_i_h, ifa.req0_op_w_i, ifa.req0_a_w_i, ifa.req0_b_w_i} = '0;
    {ifa.req1_valid_w_i_h, ifa.req1_op_w_i, ifa.req1_a_w_i, ifa.req1_b_w_i} = '0;
    {ifa.rsp0_ready_w_i_h, ifa.rsp1_ready_w_i_h} = '0;
    {ifb.req0_valid_w_i_h, ifb.req0_op_w_i, ifb.req0_a_w_i, ifb.req0_b_w_i} = '0;
    {ifb.req1_valid_w_i_h, ifb.req1_op_w_i, ifb.req1_a_w_i, ifb.req1_b_w_i} = '0;
    {ifb.rsp0_ready_w_i_h, ifb.rsp1_ready_w_i_h} = '0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy_held", ifa.busy_w_o_h, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outs", {ifa.rsp0_valid_w_o_h, ifa.rsp1_valid_w_o_h, ifa.req0_ready_w_o_h,
                     ifa.req1_ready_w_o_h, ifa.busy_w_o_h, ifa.rsp_err_w_o_h, ifa.rsp_flags_w_o}, 11'd0);
    chk("rst_res", ifa.rsp_res_w_o, 32'd0);
    chk("rst_alu_ab", {ifa.alu_a_w_o, ifa.alu_b_w_o}, 64'd0);
    chk("rst_alu_ctrl", ifa.alu_control_w_o, 4'd0);
    chk("rst_busy4", ifb.busy_w_o_h, 1'b0);

    // Single request: add 5+3
    ifa.req0_op_w_i = 4'd0; ifa.req0_a_w_i = 32'd5; ifa.req0_b_w_i = 32'd3;
    ifa.req0_valid_w_i_h = 1'b1;
    #1 chk("single_ready", {ifa.req0_ready_w_o_h, ifa.req1_ready_w_o_h}, 2'b10);
    @(negedge clk);
    ifa.req0_valid_w_i_h = 1'b0;
    chk("single_exec", {ifa.busy_w_o_h, ifa.rsp0_valid_w_o_h, ifa.rsp1_valid_w_o_h}, 3'b100);
    chk("single_alu_ab", {ifa.alu_a_w_o, ifa.alu_b_w_o}, {32'd5, 32'd3});
    @(negedge clk);
    chk("single_rsp_v", {ifa.rsp0_valid_w_o_h, ifa.rsp1_valid_w_o_h}, 2'b10);
    chk("single_res", ifa.rsp_res_w_o, 32'd8);
    chk("single_flags", ifa.rsp_flags_w_o, 5'b00101);
    chk("single_err", ifa.rsp_err_w_o_h, 1'b0);
    ifa.rsp0_ready_w_i_h = 1'b1;
    @(negedge clk);
    ifa.rsp0_ready_w_i_h = 1'b0;
    chk("single_done", {ifa.busy_w_o_h, ifa.rsp0_valid_w_o_h}, 2'b00);

    // Backpressure: slt -1 < 1 held on req1 while both requesters queue up
    ifa.req1_op_w_i = 4'd3; ifa.req1_a_w_i = 32'hFFFF_FFFF; ifa.req1_b_w_i = 32'd1;
    ifa.req1_valid_w_i_h = 1'b1;
    #1 chk("bp_ready", {ifa.req0_ready_w_o_h, ifa.req1_ready_w_o_h}, 2'b01);
    @(negedge clk);
    ifa.req1_valid_w_i_h = 1'b0;
    @(negedge clk);
    chk("bp_rsp_v", {ifa.rsp0_valid_w_o_h, ifa.rsp1_valid_w_o_h}, 2'b01);
    ifa.req0_op_w_i = 4'd1; ifa.req0_a_w_i = 32'h10; ifa.req0_b_w_i = 32'h10;
    ifa.req1_op_w_i = 4'd2; ifa.req1_a_w_i = 32'h1;  ifa.req1_b_w_i = 32'h4;
    ifa.req0_valid_w_i_h = 1'b1; ifa.req1_valid_w_i_h = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold", {ifa.rsp0_valid_w_o_h, ifa.rsp1_valid_w_o_h, ifa.req0_ready_w_o_h,
                      ifa.req1_ready_w_o_h}, 4'b0100);
      chk("bp_res", ifa.rsp_res_w_o, 32'd1);
      chk("bp_flags", ifa.rsp_flags_w_o, 5'b00110);
      @(negedge clk);
    end
    ifa.rsp0_ready_w_i_h = 1'b1; ifa.rsp1_ready_w_i_h = 1'b1;
    @(negedge clk);
    chk("hs_then_arb", {ifa.busy_w_o_h, ifa.rsp1_valid_w_o_h, ifa.req0_ready_w_o_h,
                        ifa.req1_ready_w_o_h}, 4'b0010);

    // Round-robin with both requesters held
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        got = ifa.rsp0_valid_w_o_h | ifa.rsp1_valid_w_o_h;
      end
      chk("rr_seen", got, 1'b1);
      if (k == 3) begin
        ifa.req0_valid_w_i_h = 1'b0; ifa.req1_valid_w_i_h = 1'b0;
      end
      chk("rr_grant", {ifa.rsp0_valid_w_o_h, ifa.rsp1_valid_w_o_h}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_res", ifa.rsp_res_w_o, (k % 2 == 0) ? 32'h0 : 32'h10);
      chk("rr_flags", ifa.rsp_flags_w_o, (k % 2 == 0) ? 5'b10101 : 5'b01010);
      chk("rr_ctrl", ifa.alu_control_w_o, (k % 2 == 0) ? 4'd1 : 4'd2);
      if (k > 0) chk("rr_interval", 32'(cyc - last), 32'd3);
      last = cyc;
    end
    @(negedge clk);
    ifa.rsp0_ready_w_i_h = 1'b0; ifa.rsp1_ready_w_i_h = 1'b0;
    chk("rr_idle", {ifa.busy_w_o_h, ifa.req0_ready_w_o_h, ifa.req1_ready_w_o_h}, 3'b000);

`ifdef ALU_ARB_OP_CHECK_EN
    // Illegal op skips the ALU
    ifa.req0_op_w_i = 4'hF; ifa.req0_a_w_i = 32'hDEAD; ifa.req0_b_w_i = 32'hBEEF;
    ifa.req0_valid_w_i_h = 1'b1;
    @(negedge clk);
    ifa.req0_valid_w_i_h = 1'b0;
    chk("opchk_v", {ifa.rsp0_valid_w_o_h, ifa.rsp1_valid_w_o_h}, 2'b10);
    chk("opchk_err", ifa.rsp_err_w_o_h, 1'b1);
    chk("opchk_res", {ifa.rsp_res_w_o, ifa.rsp_flags_w_o}, 37'd0);
    chk("opchk_ctrl", ifa.alu_control_w_o, 4'd2);
    chk("opchk_ab", {ifa.alu_a_w_o, ifa.alu_b_w_o}, {32'h1, 32'h4});
    ifa.rsp0_ready_w_i_h = 1'b1;
    @(negedge clk);
    ifa.rsp0_ready_w_i_h = 1'b0;
    chk("opchk_done", ifa.busy_w_o_h, 1'b0);
`endif

    // Latency 4: sra 0x80000000 by 31
    ifb.req1_op_w_i = 4'd7; ifb.req1_a_w_i = 32'h8000_0000; ifb.req1_b_w_i = 32'h1F;
    ifb.req1_valid_w_i_h = 1'b1;
    @(negedge clk);
    ifb.req1_valid_w_i_h = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lat_alu_ab", {ifb.alu_a_w_o, ifb.alu_b_w_o}, {32'h8000_0000, 32'h1F});
      chk("lat_ctrl", ifb.alu_control_w_o, 4'd7);
      chk("lat_no_v", ifb.rsp1_valid_w_o_h, 1'b0);
      @(negedge clk);
    end
    chk("lat_v", {ifb.rsp0_valid_w_o_h, ifb.rsp1_valid_w_o_h}, 2'b01);
    chk("lat_res", ifb.rsp_res_w_o, 32'hFFFF_FFFF);
    chk("lat_flags", ifb.rsp_flags_w_o, 5'b00110);
    ifb.rsp1_ready_w_i_h = 1'b1;
    @(negedge clk);
    ifb.rsp1_ready_w_i_h = 1'b0;

    // req0 op so the pointer moves to req1 before the reset test
    ifb.req0_op_w_i = 4'd0; ifb.req0_a_w_i = 32'd1; ifb.req0_b_w_i = 32'd1;
    ifb.req0_valid_w_i_h = 1'b1;
    @(negedge clk);
    ifb.req0_valid_w_i_h = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = ifb.rsp0_valid_w_o_h;
    end
    chk("q_seen", got, 1'b1);
    chk("q_res", ifb.rsp_res_w_o, 32'd2);
    ifb.rsp0_ready_w_i_h = 1'b1;
    @(negedge clk);
    ifb.rsp0_ready_w_i_h = 1'b0;

    // Reset in the middle of EXEC
    ifb.req1_op_w_i = 4'd0; ifb.req1_a_w_i = 32'd7; ifb.req1_b_w_i = 32'd8;
    ifb.req1_valid_w_i_h = 1'b1;
    #1 chk("mr_ready", {ifb.req0_ready_w_o_h, ifb.req1_ready_w_o_h}, 2'b01);
    @(negedge clk);
    ifb.req1_valid_w_i_h = 1'b0;
    chk("mr_busy", ifb.busy_w_o_h, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("mr_async", {ifb.busy_w_o_h, ifb.alu_a_w_o, ifb.alu_control_w_o}, 37'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mr_no_rsp", {ifb.rsp0_valid_w_o_h, ifb.rsp1_valid_w_o_h, ifb.busy_w_o_h}, 3'b000);
    end
    ifb.req0_valid_w_i_h = 1'b1; ifb.req1_valid_w_i_h = 1'b1;
    #1 chk("mr_ptr", {ifb.req0_ready_w_o_h, ifb.req1_ready_w_o_h}, 2'b10);
    ifb.req0_valid_w_i_h = 1'b0; ifb.req1_valid_w_i_h = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
